// File: rtl/intx_pkg.sv
// Shared message codes and FSM state encoding for the legacy INTx responder.
package intx_pkg;

  localparam logic [7:0] MSG_ASSERT_INTA   = 8'h20;
  localparam logic [7:0] MSG_DEASSERT_INTA = 8'h24;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2,
    ACK  = 2'd3
  } intx_state_e;

endpackage

// File: rtl/legacy_intx_responder_if.sv
// IRQ_REQ/IRQ_ACK handshake plus message-request bus of the INTx responder.
// Counter signals exist only when INTX_STATS_EN is defined.
interface legacy_intx_responder_if #(parameter int CNT_W = 16);
  logic       IRQ_REQ;
  logic       IRQ_ACK;
  logic       INTX_DISABLE;
  logic       MSG_VALID;
  logic       MSG_READY;
  logic [7:0] MSG_CODE;
  logic       INTX_STATUS;
  logic       PROTO_ERR;
`ifdef INTX_STATS_EN
  logic [CNT_W-1:0] ASSERT_COUNT;
  logic [CNT_W-1:0] ACK_COUNT;
`endif

  modport slave (
    input  IRQ_REQ, INTX_DISABLE, MSG_READY,
    output IRQ_ACK, MSG_VALID, MSG_CODE, INTX_STATUS, PROTO_ERR
`ifdef INTX_STATS_EN
    , output ASSERT_COUNT, ACK_COUNT
`endif
  );

  modport master (
    output IRQ_REQ, INTX_DISABLE, MSG_READY,
    input  IRQ_ACK, MSG_VALID, MSG_CODE, INTX_STATUS, PROTO_ERR
`ifdef INTX_STATS_EN
    , input ASSERT_COUNT, ACK_COUNT
`endif
  );
endinterface

// File: rtl/legacy_intx_responder.sv
// Converts IRQ_REQ level changes into Assert/Deassert_INTA message requests and
// returns IRQ_ACK once committed. Optional statistics counters: INTX_STATS_EN.
module legacy_intx_responder
  import intx_pkg::*;
#(
  parameter int ACK_DELAY = 4,
  parameter int CNT_W     = 16
) (
  input logic                    clk,
  input logic                    reset,
  legacy_intx_responder_if.slave bus
);

  if (ACK_DELAY < 0 || ACK_DELAY > 255 || CNT_W < 1) begin : g_param_chk
    $error("legacy_intx_responder: ACK_DELAY must be 0..255 and CNT_W >= 1");
  end

  intx_state_e state, state_d;
  logic        req_acked, req_acked_d;
  logic        ack_owed, ack_owed_d;
  logic        msg_valid, msg_valid_d;
  logic [7:0]  msg_code, msg_code_d;
  logic        intx_status, intx_status_d;
  logic        irq_ack, irq_ack_d;
  logic        proto_err;
  logic [7:0]  dly_cnt, dly_cnt_d;
  logic        target, hs;

  assign target = bus.IRQ_REQ & ~bus.INTX_DISABLE;
  assign hs     = msg_valid & bus.MSG_READY;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  always_comb begin
    state_d       = state;
    req_acked_d   = req_acked;
    ack_owed_d    = ack_owed;
    msg_valid_d   = msg_valid;
    msg_code_d    = msg_code;
    intx_status_d = intx_status;
    dly_cnt_d     = dly_cnt;
    irq_ack_d     = 1'b0;
    case (state)
      IDLE: begin
        // A request change wins over a disable-driven wire change.
        if (bus.IRQ_REQ != req_acked) begin
          req_acked_d = bus.IRQ_REQ;
          ack_owed_d  = 1'b1;
          if (target != intx_status) begin
            msg_code_d  = target ? MSG_ASSERT_INTA : MSG_DEASSERT_INTA;
            msg_valid_d = 1'b1;
            state_d     = SEND;
          end else begin
            irq_ack_d = 1'b1;
            state_d   = ACK;
          end
        end else if (target != intx_status) begin
          msg_code_d  = target ? MSG_ASSERT_INTA : MSG_DEASSERT_INTA;
          msg_valid_d = 1'b1;
          ack_owed_d  = 1'b0;
          state_d     = SEND;
        end
      end
      SEND: begin
        if (hs) begin
          intx_status_d = (msg_code == MSG_ASSERT_INTA);
          msg_valid_d   = 1'b0;
          dly_cnt_d     = 8'(ACK_DELAY);
          if (ACK_DELAY > 0) begin
            state_d = WAIT;
          end else if (ack_owed) begin
            irq_ack_d = 1'b1;
            state_d   = ACK;
          end else begin
            state_d = IDLE;
          end
        end
      end
      WAIT: begin
        if (dly_cnt == 8'd0) begin
          if (ack_owed) begin
            irq_ack_d = 1'b1;
            state_d   = ACK;
          end else begin
            state_d = IDLE;
          end
        end else begin
          dly_cnt_d = dly_cnt - 8'd1;
        end
      end
      ACK: begin
        ack_owed_d = 1'b0;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_acked   <= 1'b0;
      ack_owed    <= 1'b0;
      msg_valid   <= 1'b0;
      msg_code    <= MSG_DEASSERT_INTA;
      intx_status <= 1'b0;
      dly_cnt     <= 8'd0;
      irq_ack     <= 1'b0;
    end else begin
      req_acked   <= req_acked_d;
      ack_owed    <= ack_owed_d;
      msg_valid   <= msg_valid_d;
      msg_code    <= msg_code_d;
      intx_status <= intx_status_d;
      dly_cnt     <= dly_cnt_d;
      irq_ack     <= irq_ack_d;
    end
  end

  // Requester moved IRQ_REQ before its previous change was acknowledged.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      proto_err <= 1'b0;
    else if ((bus.IRQ_REQ != req_acked) && ack_owed && (state != IDLE))
      proto_err <= 1'b1;
  end

  assign bus.IRQ_ACK     = irq_ack;
  assign bus.MSG_VALID   = msg_valid;
  assign bus.MSG_CODE    = msg_code;
  assign bus.INTX_STATUS = intx_status;
  assign bus.PROTO_ERR   = proto_err;

`ifdef INTX_STATS_EN
  logic [CNT_W-1:0] assert_cnt, ack_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      assert_cnt <= '0;
      ack_cnt    <= '0;
    end else begin
      if (hs && (msg_code == MSG_ASSERT_INTA) && (assert_cnt != '1))
        assert_cnt <= assert_cnt + 1'b1;
      if (irq_ack && (ack_cnt != '1))
        ack_cnt <= ack_cnt + 1'b1;
    end
  end

  assign bus.ASSERT_COUNT = assert_cnt;
  assign bus.ACK_COUNT    = ack_cnt;
`endif

endmodule
